// File: rtl/pinwheel_bus_arbiter_if.sv
// Shared-bus arbiter signal bundle: core port, debug port and the arbitrated data bus.
// The arbiter connects through the slave modport; the driving environment uses master.
interface pinwheel_bus_arbiter_if;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wmask;
  logic        core_rden;
  logic        core_wren;
  logic [31:0] core_rdata;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [3:0]  dbg_wmask;
  logic        dbg_ack;
  logic        dbg_err;
  logic [31:0] dbg_rdata;
  logic        dbg_busy;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rden;
  logic        bus_wren;
  logic [31:0] bus_rdata;

  modport slave (
    input  core_addr, core_wdata, core_wmask, core_rden, core_wren,
    output core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wmask,
    output dbg_ack, dbg_err, dbg_rdata, dbg_busy,
    output bus_addr, bus_wdata, bus_wmask, bus_rden, bus_wren,
    input  bus_rdata
  );

  modport master (
    output core_addr, core_wdata, core_wmask, core_rden, core_wren,
    input  core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wmask,
    input  dbg_ack, dbg_err, dbg_rdata, dbg_busy,
    input  bus_addr, bus_wdata, bus_wmask, bus_rden, bus_wren,
    output bus_rdata
  );
endinterface

// File: rtl/pinwheel_bus_arbiter.sv
// Core-priority arbiter sharing one data bus between the core and a debug port.
// Define PINWHEEL_ARB_TIMEOUT_EN to abort starved debug requests after TIMEOUT_CYCLES.
module pinwheel_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input logic                    clock,
  input logic                    tick_reset_in,
  pinwheel_bus_arbiter_if.slave  arb
);

  typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } dbg_txn_t;

  if (TIMEOUT_CYCLES == 16'd0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t   state, state_nxt;
  dbg_txn_t txn;
  logic [15:0] wait_cnt, wait_nxt;
  logic core_act;
  logic take;
  logic dbg_issue;
  logic in_resp;

`ifdef PINWHEEL_ARB_TIMEOUT_EN
  logic err_q, err_nxt;
  logic timeout_hit;
  // Fires on the last permitted waiting cycle so RESP follows the TIMEOUT_CYCLES-th PEND cycle.
  assign timeout_hit = (wait_cnt >= (TIMEOUT_CYCLES - 16'd1));
`endif

  assign core_act       = arb.core_rden | arb.core_wren;
  assign arb.core_rdata = arb.bus_rdata;

  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      state    <= IDLE;
      wait_cnt <= '0;
      txn      <= '0;
`ifdef PINWHEEL_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (take) txn <= '{we: arb.dbg_we, addr: arb.dbg_addr,
                         wdata: arb.dbg_wdata, wmask: arb.dbg_wmask};
`ifdef PINWHEEL_ARB_TIMEOUT_EN
      err_q    <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    take      = 1'b0;
    dbg_issue = 1'b0;
`ifdef PINWHEEL_ARB_TIMEOUT_EN
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        if (arb.dbg_req) begin
          take      = 1'b1;
          wait_nxt  = '0;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (!core_act) begin
          dbg_issue = 1'b1;
          state_nxt = RESP;
`ifdef PINWHEEL_ARB_TIMEOUT_EN
          err_nxt   = 1'b0;
        end else if (timeout_hit) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
`endif
        end else if (wait_cnt != 16'hFFFF) begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Core always wins the bus; a debug access only goes out in a core-idle PEND cycle.
    arb.bus_addr  = '0;
    arb.bus_wdata = '0;
    arb.bus_wmask = '0;
    arb.bus_rden  = 1'b0;
    arb.bus_wren  = 1'b0;
    if (core_act) begin
      arb.bus_addr  = arb.core_addr;
      arb.bus_wdata = arb.core_wdata;
      arb.bus_wmask = arb.core_wmask;
      arb.bus_rden  = arb.core_rden;
      arb.bus_wren  = arb.core_wren;
    end else if (dbg_issue && !tick_reset_in) begin
      arb.bus_addr  = txn.addr;
      arb.bus_wdata = txn.wdata;
      arb.bus_wmask = txn.wmask;
      arb.bus_rden  = !txn.we;
      arb.bus_wren  = txn.we;
    end

    in_resp       = !tick_reset_in && (state == RESP);
    arb.dbg_busy  = !tick_reset_in && (state != IDLE);
    arb.dbg_ack   = in_resp;
    arb.dbg_rdata = '0;
`ifdef PINWHEEL_ARB_TIMEOUT_EN
    arb.dbg_err   = in_resp && err_q;
    if (in_resp && !txn.we && !err_q) arb.dbg_rdata = arb.bus_rdata;
`else
    arb.dbg_err   = 1'b0;
    if (in_resp && !txn.we) arb.dbg_rdata = arb.bus_rdata;
`endif
  end

endmodule

// File: doc/pinwheel_bus_arbiter.md
PINWHEEL_BUS_ARBITER -- requirements
Module: pinwheel_bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 16'd1000, meaning the number of pending cycles before a debug request is aborted (legal range 1..65535).
REQ-002 clock  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 tick_reset_in  in  1  reset, synchronous and active-high.
REQ-004 core_addr / core_wdata  in  32 / 32  core data-bus address and write data.
REQ-005 core_wmask  in  4  core byte write mask.
REQ-006 core_rden / core_wren  in  1 / 1  core read and write strobes.
REQ-007 core_rdata  out  32  read data returned to the core.
REQ-008 dbg_req  in  1  debug request; held high with stable fields until dbg_ack.
REQ-009 dbg_we  in  1  debug request is a write.
REQ-010 dbg_addr / dbg_wdata  in  32 / 32  debug address and write data.
REQ-011 dbg_wmask  in  4  debug byte write mask.
REQ-012 dbg_ack / dbg_err  out  1 / 1  debug completion pulse and abort flag.
REQ-013 dbg_rdata  out  32  debug read data.
REQ-014 dbg_busy  out  1  debug transaction in flight.
REQ-015 bus_addr / bus_wdata  out  32 / 32  shared data bus address and write data.
REQ-016 bus_wmask  out  4  shared data bus byte mask.
REQ-017 bus_rden / bus_wren  out  1 / 1  shared data bus strobes.
REQ-018 bus_rdata  in  32  shared data bus read data, valid one cycle after the address.

Function
REQ-019 The core SHALL have absolute priority: when core_rden|core_wren, bus_* SHALL equal core_* combinationally, with zero added latency.
REQ-020 core_rdata SHALL equal bus_rdata combinationally in every cycle.
REQ-021 The block SHALL implement a debug FSM with states IDLE, PEND and RESP, and dbg_busy SHALL be 1 whenever the state is not IDLE.
REQ-022 IDLE: when dbg_req=1, the block SHALL latch dbg_we, dbg_addr, dbg_wdata and dbg_wmask, clear the wait counter, and move to PEND.
REQ-023 PEND with the core idle: the bus SHALL carry the latched request (bus_rden=!we, bus_wren=we), and the next state SHALL be RESP.
REQ-024 PEND with the core active: the bus SHALL carry the core access, the wait counter SHALL increment (saturating at 16 bits), and the state SHALL remain PEND.
REQ-025 RESP: dbg_ack SHALL be 1 for exactly one cycle; dbg_rdata SHALL be bus_rdata for a read and 0 for a write; the next state SHALL be IDLE.
REQ-026 Minimum debug latency SHALL be 2 cycles from sampling dbg_req to dbg_ack.
REQ-027 A dbg_req still high in the IDLE cycle after dbg_ack SHALL start a new transaction; the requester drops dbg_req in that cycle to avoid it.
REQ-028 When no access is driven, bus_rden=bus_wren=0 and bus_addr, bus_wdata and bus_wmask SHALL be 0.
REQ-029 Outside RESP, dbg_ack=0, dbg_err=0 and dbg_rdata=0.
REQ-030 bus_rden and bus_wren SHALL never both be 1; a core access with both strobes set SHALL be forwarded as-is (core error, not arbitrated).

Reset
REQ-031 When tick_reset_in=1: state=IDLE, wait counter=0, latched fields=0.
REQ-032 All outputs SHALL be 0 during reset except the core pass-through paths.
REQ-033 Reset mid-transaction SHALL abandon it, with no dbg_ack and no further bus access.

Configuration
REQ-034 With PINWHEEL_ARB_TIMEOUT_EN defined, when PEND has waited TIMEOUT_CYCLES cycles the FSM SHALL go to RESP without a bus access, asserting dbg_ack=1, dbg_err=1 and dbg_rdata=0.
REQ-035 Without PINWHEEL_ARB_TIMEOUT_EN, PEND SHALL wait indefinitely, dbg_err SHALL be tied 0, and no timeout comparator SHALL be instantiated.

Verification
REQ-036 Core idle; dbg read of addr 0x80000010, bus_rdata=0xDEADBEEF -> bus_rden in cycle 1 with bus_addr=0x80000010; dbg_ack in cycle 2 with dbg_rdata=0xDEADBEEF.
REQ-037 Core writes every cycle for 5 cycles while dbg write (0x80000020, 0x12345678, 4'b1111) is pending -> bus shows only core accesses for 5 cycles; debug write issued in the first idle cycle; ack one cycle later with dbg_rdata=0.
REQ-038 Back-to-back debug requests with dbg_req held high after ack -> second transaction latched in the following IDLE cycle; exactly two acks.
REQ-039 With the macro defined and TIMEOUT_CYCLES=4, core busy continuously -> ack with dbg_err=1 after 4 PEND cycles; no debug strobe ever appears on the bus.
REQ-040 tick_reset_in asserted during PEND -> next cycle state=IDLE, dbg_busy=0, no ack and no debug bus access.
REQ-041 Core read at 0x80000000 coincident with dbg_req -> bus carries the core read that cycle; core_rdata tracks bus_rdata the next cycle.
